// File: rtl/uart_tx_peripheral_pkg.sv
// Shared register offsets, STATUS bit positions and FSM encodings for the
// memory-mapped UART transmitter.
package uart_tx_peripheral_pkg;

  localparam logic [1:0] UART_REG_TXDATA = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_REG_DIV_LO = 2'd2;
  localparam logic [1:0] UART_REG_DIV_HI = 2'd3;

  localparam int unsigned STB_HOLD_FULL = 0;
  localparam int unsigned STB_SHIFTING  = 1;
  localparam int unsigned STB_DONE      = 2;
  localparam int unsigned STB_OVERRUN   = 3;

  localparam logic [1:0] FSM_IDLE  = 2'd0;
  localparam logic [1:0] FSM_START = 2'd1;
  localparam logic [1:0] FSM_DATA  = 2'd2;
  localparam logic [1:0] FSM_STOP  = 2'd3;

  typedef struct packed {
    logic overrun;
    logic done;
    logic shifting;
    logic hold_full;
  } status_t;

  function automatic logic [7:0] pack_status(input status_t s);
    return {4'b0000, s};
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// 8N1 serialiser: start bit, eight data bits LSB first, stop bit, each lasting
// div+1 clocks. A load accepted at the end of STOP chains frames with no gap.
module uart_tx_shifter
  import uart_tx_peripheral_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  data_in,
  input  logic [15:0] div,
  output logic        ready,
  output logic        frame_done,
  output logic        tx
);

  logic [1:0]  r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        w_baud_zero;

  assign w_baud_zero = (r_baud == 16'd0);
  assign frame_done  = (r_state == FSM_STOP) && w_baud_zero;
  // The last clock of the stop bit can accept the next byte directly.
  assign ready       = (r_state == FSM_IDLE) || frame_done;
  assign tx          = r_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FSM_IDLE;
      r_baud    <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        FSM_IDLE: begin
          if (load) begin
            r_shift <= data_in;
            r_tx    <= 1'b0;
            r_baud  <= div;
            r_state <= FSM_START;
          end
        end
        FSM_START: begin
          if (!w_baud_zero) begin
            r_baud <= r_baud - 16'd1;
          end else begin
            r_tx      <= r_shift[0];
            r_bit_idx <= 3'd0;
            r_baud    <= div;
            r_state   <= FSM_DATA;
          end
        end
        FSM_DATA: begin
          if (!w_baud_zero) begin
            r_baud <= r_baud - 16'd1;
          end else begin
            r_baud <= div;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= FSM_STOP;
            end else begin
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        FSM_STOP: begin
          if (!w_baud_zero) begin
            r_baud <= r_baud - 16'd1;
          end else if (load) begin
            r_shift <= data_in;
            r_tx    <= 1'b0;
            r_baud  <= div;
            r_state <= FSM_START;
          end else begin
            r_state <= FSM_IDLE;
          end
        end
        default: begin
          r_state <= FSM_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_peripheral.sv
// CPU-bus responder for the UART transmitter: address decode, one-deep holding
// register, sticky status flags and the programmable bit-period divider.
module uart_tx_peripheral
  import uart_tx_peripheral_pkg::*;
#(
  parameter logic [31:0] BASE        = 32'h0000_2000,
  parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [7:0]  write_data,
  input  logic        write_enable,
  output logic [7:0]  read_data,
  output logic        selected,
  output logic        tx,
  output logic        irq_done
);

  logic [31:0] w_offset;
  logic [1:0]  w_reg;
  logic        w_wr;
  logic        w_wr_txdata;
  logic        w_wr_status;
  logic        w_load;
  logic        w_accept;
  logic        w_reject;
  logic        w_ready;
  logic        w_frame_done;
  logic        w_tx;
  status_t     w_status;

  logic [7:0]  r_txdata;
  logic [15:0] r_div;
  logic        r_hold_full;
  logic        r_shifting;
  logic        r_done;
  logic        r_overrun;

  // Wrapping subtraction makes addresses below BASE decode as out of range.
  assign w_offset    = address - BASE;
  assign selected    = (w_offset < 32'd4);
  assign w_reg       = w_offset[1:0];
  assign w_wr        = write_enable && selected;
  assign w_wr_txdata = w_wr && (w_reg == UART_REG_TXDATA);
  assign w_wr_status = w_wr && (w_reg == UART_REG_STATUS);

  // A full holding register still accepts a byte when it empties this cycle.
  assign w_load   = r_hold_full && w_ready;
  assign w_accept = w_wr_txdata && (!r_hold_full || w_load);
  assign w_reject = w_wr_txdata && !w_accept;

  uart_tx_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .data_in    (r_txdata),
    .div        (r_div),
    .ready      (w_ready),
    .frame_done (w_frame_done),
    .tx         (w_tx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txdata    <= 8'd0;
      r_div       <= DEFAULT_DIV;
      r_hold_full <= 1'b0;
      r_shifting  <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_txdata    <= write_data;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      if (w_load) begin
        r_shifting <= 1'b1;
      end else if (w_frame_done) begin
        r_shifting <= 1'b0;
      end

      // Sticky flags: a new event outranks a simultaneous write-1-to-clear.
      if (w_frame_done) begin
        r_done <= 1'b1;
      end else if (w_wr_status && write_data[STB_DONE]) begin
        r_done <= 1'b0;
      end

      if (w_reject) begin
        r_overrun <= 1'b1;
      end else if (w_wr_status && write_data[STB_OVERRUN]) begin
        r_overrun <= 1'b0;
      end

      if (w_wr && (w_reg == UART_REG_DIV_LO)) begin
        r_div[7:0] <= write_data;
      end
      if (w_wr && (w_reg == UART_REG_DIV_HI)) begin
        r_div[15:8] <= write_data;
      end
    end
  end

  assign w_status.hold_full = r_hold_full;
  assign w_status.shifting  = r_shifting;
  assign w_status.done      = r_done;
  assign w_status.overrun   = r_overrun;

  always_comb begin
    read_data = 8'd0;
    if (selected) begin
      case (w_reg)
        UART_REG_TXDATA: read_data = r_txdata;
        UART_REG_STATUS: read_data = pack_status(w_status);
        UART_REG_DIV_LO: read_data = r_div[7:0];
        UART_REG_DIV_HI: read_data = r_div[15:8];
        default:         read_data = 8'd0;
      endcase
    end
  end

  assign tx       = w_tx;
  assign irq_done = r_done;

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Directed bench for uart_tx_peripheral: a register-access vector table plus
// hand-built frame sequences compared against expected tx waveforms.
module tb_uart_tx_peripheral;

  localparam logic [31:0] BASE = 32'h0000_2000;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic [7:0]  write_data;
  logic        write_enable;
  logic [7:0]  read_data;
  logic        selected;
  logic        tx;
  logic        irq_done;

  int checks;
  int failures;

  logic cap_en;
  logic cap_q[$];
  logic exp_q[$];

  uart_tx_peripheral #(
    .BASE        (BASE),
    .DEFAULT_DIV (16'd103)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_data    (read_data),
    .selected     (selected),
    .tx           (tx),
    .irq_done     (irq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  exp_rd;
    logic        exp_sel;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cap_en) cap_q.push_back(tx);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    address      = a;
    write_data   = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic chk_rd(input string name, input logic [31:0] a, input logic [7:0] exp);
    address      = a;
    write_enable = 1'b0;
    #1;
    chk(name, {24'd0, read_data}, {24'd0, exp});
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    write_enable = 1'b0;
    address      = 32'd0;
    write_data   = 8'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic add_bits(input logic v, input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] b, input int per);
    add_bits(1'b0, per);
    for (int i = 0; i < 8; i++) add_bits(b[i], per);
    add_bits(1'b1, per);
  endtask

  task automatic cmp_cap(input string name);
    int mism;
    mism = 0;
    chk({name, "_len"}, (cap_q.size() >= exp_q.size()) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= cap_q.size()) mism++;
      else if (cap_q[i] !== exp_q[i]) mism++;
    end
    chk(name, mism, 32'd0);
    $display("seq %s: %0d tx samples compared, %0d differ", name, exp_q.size(), mism);
  endtask

  task automatic start_capture();
    cap_q.delete();
    exp_q.delete();
    cap_en = 1'b1;
  endtask

  initial begin
    int zeros;
    checks       = 0;
    failures     = 0;
    cap_en       = 1'b0;
    rst          = 1'b1;
    address      = 32'd0;
    write_data   = 8'd0;
    write_enable = 1'b0;

    // ---------------- register-access table ----------------
    vecs[0]  = '{BASE + 32'd1, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{BASE + 32'd2, 8'h00, 1'b0, 8'h67, 1'b1};
    vecs[2]  = '{BASE + 32'd3, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[3]  = '{BASE,         8'h00, 1'b0, 8'h00, 1'b1};
    vecs[4]  = '{BASE + 32'd4, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{BASE - 32'd1, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{BASE + 32'd4, 8'h55, 1'b1, 8'h00, 1'b0};
    vecs[7]  = '{BASE - 32'd1, 8'hAA, 1'b1, 8'h00, 1'b0};
    vecs[8]  = '{32'h0000_0000, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{BASE + 32'd2, 8'h67, 1'b0, 8'h67, 1'b1};
    vecs[10] = '{BASE + 32'd2, 8'h07, 1'b1, 8'h67, 1'b1};
    vecs[11] = '{BASE + 32'd2, 8'h00, 1'b0, 8'h07, 1'b1};
    vecs[12] = '{BASE + 32'd3, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[13] = '{BASE,         8'h00, 1'b0, 8'h00, 1'b1};
    vecs[14] = '{BASE + 32'd1, 8'h00, 1'b0, 8'h00, 1'b1};

    do_reset();
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_irq", {31'd0, irq_done}, 32'd0);

    for (int v = 0; v < 15; v++) begin
      address      = vecs[v].addr;
      write_data   = vecs[v].wdata;
      write_enable = vecs[v].we;
      #1;
      chk($sformatf("vec%0d_rd", v), {24'd0, read_data}, {24'd0, vecs[v].exp_rd});
      chk($sformatf("vec%0d_sel", v), {31'd0, selected}, {31'd0, vecs[v].exp_sel});
      $display("vec %0d addr=%08h we=%0b wdata=%02h rd=%02h sel=%0b",
               v, vecs[v].addr, vecs[v].we, vecs[v].wdata, read_data, selected);
      tick();
      write_enable = 1'b0;
    end
    chk("table_tx_idle", {31'd0, tx}, 32'd1);

    // ---------------- A: DIV=0, single A5 frame ----------------
    do_reset();
    wr(BASE + 32'd2, 8'h00);
    start_capture();
    wr(BASE, 8'hA5);
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i == 10) chk_rd("A_status_mid", BASE + 32'd1, 8'h02);
    end
    add_bits(1'b1, 1);
    add_frame(8'hA5, 1);
    add_bits(1'b1, 1);
    cmp_cap("A_frame");
    chk_rd("A_status_end", BASE + 32'd1, 8'h04);
    chk_rd("A_txdata", BASE, 8'hA5);
    chk("A_irq", {31'd0, irq_done}, 32'd1);

    // done cleared in the very cycle it is set again: set must win
    wr(BASE, 8'h00);
    for (int i = 0; i < 10; i++) tick();
    wr(BASE + 32'd1, 8'h04);
    chk_rd("A_done_set_wins", BASE + 32'd1, 8'h04);
    wr(BASE + 32'd1, 8'h04);
    chk_rd("A_done_clear", BASE + 32'd1, 8'h00);
    chk("A_irq_clear", {31'd0, irq_done}, 32'd0);

    // ---------------- B: DIV=3, back-to-back 00 / FF ----------------
    do_reset();
    wr(BASE + 32'd2, 8'h03);
    start_capture();
    wr(BASE, 8'h00);
    wr(BASE, 8'hFF);
    chk_rd("B_status_both_held", BASE + 32'd1, 8'h03);
    for (int i = 2; i <= 81; i++) begin
      tick();
      if (i == 41) chk_rd("B_status_second_load", BASE + 32'd1, 8'h06);
    end
    add_bits(1'b1, 1);
    add_frame(8'h00, 4);
    add_frame(8'hFF, 4);
    add_bits(1'b1, 1);
    cmp_cap("B_frames");
    chk_rd("B_status_end", BASE + 32'd1, 8'h04);

    // ---------------- C: overrun ----------------
    do_reset();
    wr(BASE + 32'd2, 8'h03);
    start_capture();
    wr(BASE, 8'h11);
    tick();
    wr(BASE, 8'h22);
    wr(BASE, 8'h33);
    chk_rd("C_status_overrun", BASE + 32'd1, 8'h0B);
    chk_rd("C_txdata_kept", BASE, 8'h22);
    wr(BASE + 32'd1, 8'h08);
    chk_rd("C_overrun_clear", BASE + 32'd1, 8'h03);
    for (int i = 0; i < 200 && cap_q.size() < 91; i++) tick();
    add_bits(1'b1, 1);
    add_frame(8'h11, 4);
    add_frame(8'h22, 4);
    add_bits(1'b1, 10);
    cmp_cap("C_frames");
    chk_rd("C_status_end", BASE + 32'd1, 8'h04);

    // ---------------- D: DIV=7 programmed through both bytes ----------------
    do_reset();
    wr(BASE + 32'd2, 8'h07);
    wr(BASE + 32'd3, 8'h00);
    chk_rd("D_div_lo", BASE + 32'd2, 8'h07);
    chk_rd("D_div_hi", BASE + 32'd3, 8'h00);
    start_capture();
    wr(BASE, 8'h3C);
    for (int i = 0; i < 300 && cap_q.size() < 84; i++) tick();
    add_bits(1'b1, 1);
    add_frame(8'h3C, 8);
    add_bits(1'b1, 3);
    cmp_cap("D_frame");

    // ---------------- E: reset in the middle of DATA ----------------
    do_reset();
    cap_en = 1'b0;
    wr(BASE + 32'd2, 8'h03);
    wr(BASE, 8'hF0);
    for (int i = 0; i < 9; i++) tick();
    chk("E_tx_low_before_rst", {31'd0, tx}, 32'd0);
    chk_rd("E_status_before_rst", BASE + 32'd1, 8'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("E_tx_after_rst", {31'd0, tx}, 32'd1);
    chk_rd("E_status_after_rst", BASE + 32'd1, 8'h00);
    chk_rd("E_div_after_rst", BASE + 32'd2, 8'h67);
    chk_rd("E_txdata_after_rst", BASE, 8'h00);
    chk("E_irq_after_rst", {31'd0, irq_done}, 32'd0);
    zeros = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx !== 1'b1) zeros++;
    end
    chk("E_tx_quiet", zeros, 32'd0);
    $display("seq E: reset mid-frame, %0d low samples afterwards", zeros);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
